// File: rtl/drv_keyscan3_if.sv
// Keypad scan bus: row sense in, column drive and decoded-key results out.
interface drv_keyscan3_if;
   logic [3:0] row;
   logic [2:0] col;
   logic [9:0] data;
   logic       key_valid;
   logic [3:0] key_code;

   modport slave  (input row, output col, data, key_valid, key_code);
   modport master (output row, input col, data, key_valid, key_code);
endinterface

// File: rtl/drv_keyscan3.sv
// 4x3 keypad scanner with frame debounce and 3-digit decimal entry.
// Optional KEYSCAN_ECHO_EN: data mirrors the accumulator on digits and clears on *.
module drv_keyscan3 #(
   parameter int DEB_FRAMES = 4
) (
   input logic           clk,
   input logic           rstn,
   drv_keyscan3_if.slave kp
);

   localparam logic [3:0] DEB = 4'(DEB_FRAMES);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

   state_t     state, state_nx;
   logic [2:0] col_q;
   logic [2:0] cand_col, cand_col_nx;
   logic [3:0] cand_row, cand_row_nx;
   logic [3:0] cand_code, cand_code_nx;
   logic [3:0] press_cnt, press_nx;
   logic [3:0] rel_cnt, rel_nx;
   logic       confirm;
   logic       samp_valid, in_col, same, row_clear;
   logic [9:0] acc, acc_dig, data_q;
   logic [1:0] dcnt;
   logic       kv_q;
   logic [3:0] kc_q;

   function automatic logic [3:0] key_lut(input logic [3:0] r, input logic [2:0] c);
      logic [1:0] ri, ci;
      logic [3:0] t;
      ri = r[0] ? 2'd0 : r[1] ? 2'd1 : r[2] ? 2'd2 : 2'd3;
      ci = c[0] ? 2'd0 : c[1] ? 2'd1 : 2'd2;
      case ({ri, ci})
         4'h0: t = 4'd1;  4'h1: t = 4'd2;  4'h2: t = 4'd3;
         4'h4: t = 4'd4;  4'h5: t = 4'd5;  4'h6: t = 4'd6;
         4'h8: t = 4'd7;  4'h9: t = 4'd8;  4'hA: t = 4'd9;
         4'hC: t = 4'hA;  4'hD: t = 4'd0;  4'hE: t = 4'hB;
         default: t = 4'd0;
      endcase
      return t;
   endfunction

   // row is judged against the column driven during the cycle that just ended
   assign samp_valid = $onehot(kp.row);
   assign in_col     = (col_q == cand_col);
   assign same       = in_col && samp_valid && (kp.row == cand_row);
   assign row_clear  = (kp.row & cand_row) == 4'd0;

   always_comb begin
      state_nx     = state;
      cand_col_nx  = cand_col;
      cand_row_nx  = cand_row;
      cand_code_nx = cand_code;
      press_nx     = press_cnt;
      rel_nx       = rel_cnt;
      confirm      = 1'b0;
      case (state)
         IDLE: if (samp_valid) begin
            cand_col_nx  = col_q;
            cand_row_nx  = kp.row;
            cand_code_nx = key_lut(kp.row, col_q);
            press_nx     = 4'd1;
            if (DEB == 4'd1) begin
               confirm  = 1'b1;
               state_nx = HELD;
            end else begin
               state_nx = DEBOUNCE;
            end
         end
         DEBOUNCE: if (in_col) begin
            if (same) begin
               press_nx = press_cnt + 4'd1;
               if (press_nx == DEB) begin
                  confirm  = 1'b1;
                  state_nx = HELD;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         HELD: if (in_col && row_clear) begin
            rel_nx   = 4'd1;
            state_nx = (DEB == 4'd1) ? IDLE : RELEASE;
         end
         RELEASE: if (in_col) begin
            if (row_clear) begin
               rel_nx = rel_cnt + 4'd1;
               if (rel_nx == DEB) state_nx = IDLE;
            end else begin
               state_nx = HELD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // acc <= 99 whenever a digit is accepted, so the 10-bit product cannot wrap
   assign acc_dig = 10'(acc * 10'd10) + {6'd0, cand_code_nx};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         col_q     <= 3'b001;
         cand_col  <= 3'b001;
         cand_row  <= 4'd0;
         cand_code <= 4'd0;
         press_cnt <= 4'd0;
         rel_cnt   <= 4'd0;
         acc       <= 10'd0;
         dcnt      <= 2'd0;
         data_q    <= 10'd0;
         kv_q      <= 1'b0;
         kc_q      <= 4'd0;
      end else begin
         state     <= state_nx;
         col_q     <= {col_q[1:0], col_q[2]};
         cand_col  <= cand_col_nx;
         cand_row  <= cand_row_nx;
         cand_code <= cand_code_nx;
         press_cnt <= press_nx;
         rel_cnt   <= rel_nx;
         kv_q      <= confirm;
         if (confirm) begin
            kc_q <= cand_code_nx;
            if (cand_code_nx < 4'd10) begin
               if (dcnt < 2'd3) begin
                  acc  <= acc_dig;
                  dcnt <= dcnt + 2'd1;
`ifdef KEYSCAN_ECHO_EN
                  data_q <= acc_dig;
`endif
               end
            end else if (cand_code_nx == 4'hA) begin
               acc  <= 10'd0;
               dcnt <= 2'd0;
`ifdef KEYSCAN_ECHO_EN
               data_q <= 10'd0;
`endif
            end else begin
               data_q <= acc;
               acc    <= 10'd0;
               dcnt   <= 2'd0;
            end
         end
      end
   end

   assign kp.col       = col_q;
   assign kp.data      = data_q;
   assign kp.key_valid = kv_q;
   assign kp.key_code  = kc_q;

endmodule

// File: tb/tb_drv_keyscan3.sv
// Directed bench for drv_keyscan3: keypad model drives row from col and the held key.
module tb_drv_keyscan3;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   key = -1;
   logic raw_en = 1'b0;
   logic [3:0] raw_row = 4'd0;
   logic [3:0] pad_row;
   int   total = 0;
   int   bad = 0;

   drv_keyscan3_if kp ();
   drv_keyscan3 #(.DEB_FRAMES(4)) dut (.clk(clk), .rstn(rstn), .kp(kp));

   always #5 clk = ~clk;

   function automatic int krow(input int k);
      if (k >= 1 && k <= 9) return (k - 1) / 3;
      return 3;
   endfunction
   function automatic int kcol(input int k);
      if (k >= 1 && k <= 9) return (k - 1) % 3;
      if (k == 10) return 0;
      if (k == 11) return 2;
      return 1;
   endfunction

   always_comb begin
      pad_row = 4'd0;
      if (key >= 0 && ((kp.col >> kcol(key)) & 3'd1) != 3'd0)
         pad_row = 4'd1 << krow(key);
   end
   assign kp.row = raw_en ? raw_row : pad_row;

   // press key k (or -1 for none) for n cycles, counting key_valid pulses
   task automatic hold(input int k, input int n, output int pulses);
      pulses = 0;
      @(negedge clk);
      key = k;
      repeat (n) begin
         @(negedge clk);
         if (kp.key_valid) pulses++;
      end
   endtask

   task automatic tap(input int k, output int pulses);
      int p2;
      hold(k, 18, pulses);
      hold(-1, 18, p2);
      pulses += p2;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (kp.col !== 3'b001) begin bad++; $display("FAIL reset_col got=%b exp=001", kp.col); end
      total++; if (kp.data !== 10'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", kp.data); end
      total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL reset_kv got=%b exp=0", kp.key_valid); end
      total++; if (kp.key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", kp.key_code); end
      rstn = 1'b1;
   endtask

   task automatic test_scan;
      logic [2:0] exp_col [3];
      exp_col[0] = 3'b010; exp_col[1] = 3'b100; exp_col[2] = 3'b001;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (kp.col !== exp_col[i]) begin bad++; $display("FAIL scan_col step=%0d got=%b exp=%b", i, kp.col, exp_col[i]); end
      end
   endtask

   task automatic test_press5;
      int nsamp, pulses, p;
      logic [2:0] cb;
      nsamp = 0; pulses = 0;
      @(negedge clk);
      key = 5;
      repeat (18) begin
         cb = kp.col;
         @(posedge clk);
         #1;
         if (cb == 3'b010) nsamp++;
         if (kp.key_valid) begin
            pulses++;
            if (pulses == 1) begin
               total++;
               if (nsamp != 4 || cb != 3'b010) begin
                  bad++; $display("FAIL press5_latency samples=%0d col=%b exp samples=4 col=010", nsamp, cb);
               end
            end
         end
         @(negedge clk);
      end
      hold(-1, 18, p);
      pulses += p;
      total++; if (pulses != 1) begin bad++; $display("FAIL press5_pulses got=%0d exp=1", pulses); end
      total++; if (kp.key_code !== 4'd5) begin bad++; $display("FAIL press5_code got=%0d exp=5", kp.key_code); end
`ifdef KEYSCAN_ECHO_EN
      total++; if (kp.data !== 10'd5) begin bad++; $display("FAIL press5_data got=%0d exp=5", kp.data); end
`else
      total++; if (kp.data !== 10'd0) begin bad++; $display("FAIL press5_data got=%0d exp=0", kp.data); end
`endif
      tap(10, p);
   endtask

   task automatic test_seq123;
      int p;
      int keys [4] = '{1, 2, 3, 11};
`ifdef KEYSCAN_ECHO_EN
      int expd [4] = '{1, 12, 123, 123};
`else
      int expd [4] = '{0, 0, 0, 123};
`endif
      for (int i = 0; i < 4; i++) begin
         tap(keys[i], p);
         total++; if (p != 1) begin bad++; $display("FAIL seq123_pulses key=%0d got=%0d exp=1", keys[i], p); end
         total++; if (kp.key_code !== 4'(keys[i])) begin bad++; $display("FAIL seq123_code got=%0d exp=%0d", kp.key_code, keys[i]); end
         total++; if (kp.data !== 10'(expd[i])) begin bad++; $display("FAIL seq123_data key=%0d got=%0d exp=%0d", keys[i], kp.data, expd[i]); end
      end
   endtask

   task automatic test_fourth_digit;
      int p;
      int keys [8] = '{9, 9, 9, 7, 11, 10, 4, 11};
`ifdef KEYSCAN_ECHO_EN
      int expd [8] = '{9, 99, 999, 999, 999, 0, 4, 4};
`else
      int expd [8] = '{123, 123, 123, 123, 999, 999, 999, 4};
`endif
      for (int i = 0; i < 8; i++) begin
         tap(keys[i], p);
         total++; if (p != 1) begin bad++; $display("FAIL digits_pulses key=%0d got=%0d exp=1", keys[i], p); end
         total++; if (kp.data !== 10'(expd[i])) begin bad++; $display("FAIL digits_data step=%0d got=%0d exp=%0d", i, kp.data, expd[i]); end
      end
   endtask

   task automatic test_bounce;
      int p1, p2, p3, p4;
      hold(8, 6, p1);
      hold(-1, 3, p2);
      hold(8, 12, p3);
      hold(-1, 18, p4);
      total++; if (p1 + p2 != 0) begin bad++; $display("FAIL bounce_early got=%0d exp=0", p1 + p2); end
      total++; if (p3 + p4 != 1) begin bad++; $display("FAIL bounce_run got=%0d exp=1", p3 + p4); end
      total++; if (kp.key_code !== 4'd8) begin bad++; $display("FAIL bounce_code got=%0d exp=8", kp.key_code); end
      raw_row = 4'b0101;
      raw_en = 1'b1;
      hold(-1, 24, p1);
      raw_en = 1'b0;
      total++; if (p1 != 0) begin bad++; $display("FAIL multirow got=%0d exp=0", p1); end
      tap(10, p1);
   endtask

   task automatic test_reset_held;
      int p;
      tap(7, p);
      hold(0, 18, p);
      total++; if (p != 1) begin bad++; $display("FAIL held0_pulses got=%0d exp=1", p); end
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (kp.col !== 3'b001 || kp.data !== 10'd0 || kp.key_valid !== 1'b0 || kp.key_code !== 4'd0) begin
         bad++; $display("FAIL held_reset col=%b data=%0d kv=%b code=%0d exp 001/0/0/0", kp.col, kp.data, kp.key_valid, kp.key_code);
      end
      rstn = 1'b1;
      hold(0, 18, p);
      total++; if (p != 1) begin bad++; $display("FAIL rearm_pulses got=%0d exp=1", p); end
      total++; if (kp.key_code !== 4'd0) begin bad++; $display("FAIL rearm_code got=%0d exp=0", kp.key_code); end
      hold(-1, 18, p);
      tap(11, p);
      total++; if (kp.data !== 10'd0) begin bad++; $display("FAIL rearm_acc got=%0d exp=0", kp.data); end
   endtask

   task automatic test_echo;
      int p;
      tap(6, p); tap(11, p);
      tap(4, p);
`ifdef KEYSCAN_ECHO_EN
      total++; if (kp.data !== 10'd4) begin bad++; $display("FAIL echo_4 got=%0d exp=4", kp.data); end
      tap(2, p);
      total++; if (kp.data !== 10'd42) begin bad++; $display("FAIL echo_42 got=%0d exp=42", kp.data); end
      tap(10, p);
      total++; if (kp.data !== 10'd0) begin bad++; $display("FAIL echo_star got=%0d exp=0", kp.data); end
`else
      total++; if (kp.data !== 10'd6) begin bad++; $display("FAIL noecho_4 got=%0d exp=6", kp.data); end
      tap(2, p);
      total++; if (kp.data !== 10'd6) begin bad++; $display("FAIL noecho_42 got=%0d exp=6", kp.data); end
      tap(10, p);
      total++; if (kp.data !== 10'd6) begin bad++; $display("FAIL noecho_star got=%0d exp=6", kp.data); end
`endif
   endtask

   initial begin
      test_reset;
      test_scan;
      test_press5;
      test_seq123;
      test_fourth_digit;
      test_bounce;
      test_reset_held;
      test_echo;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
